mux_ndff_tx_arb: RTL
====================

// Module: mux_ndff_tx_arb
// PURPOSE
//  Source-domain arbiter and sequencer for one shared mux+n-flop CDC channel.
//  Accepts words from N_REQ requesters by round-robin and drives one (data, en) pair into the channel.
//  Holds data stable and en high for EN_CYC cycles, then forces en low for GAP_CYC cycles before the next word.
//  Sits in the clka domain, directly ahead of the macro_mux_ndff destination synchronizer.
// PARAMETERS
//  N_REQ    4  number of requesters, >=2
//  DATA_W   8  payload width per requester
//  EN_CYC   3  cycles cdc_en held high per transfer, >=1
//  GAP_CYC  4  minimum cycles cdc_en held low between transfers, >=1
// PORTS
//  clk        in   1             source clock; single clock domain
//  rst        in   1             asynchronous, active-high reset
//  req_valid  in   N_REQ         per-requester word available
//  req_data   in   N_REQ*DATA_W  packed payloads; slice i = requester i
//  req_ready  out  N_REQ         one-hot accept, asserted in the accept cycle
//  cdc_data   out  OUT_W         registered payload to channel; OUT_W=DATA_W, or DATA_W+IDX_W with tag
//  cdc_en     out  1             registered enable pulse to channel
//  busy       out  1             high whenever state != IDLE
//  grant_idx  out  IDX_W         index of last accepted requester; IDX_W=$clog2(N_REQ)
// BEHAVIOUR
//  Reset values: cdc_en=0, cdc_data=0, grant_idx=0, busy=0, rr_ptr=0, state=IDLE, counter=0.
//  req_ready is combinational and is 0 during reset.
//  FSM: IDLE -> HOLD -> GAP -> IDLE.
//   IDLE: if any req_valid, winner = first valid index at or after rr_ptr, wrapping modulo N_REQ.
//    req_ready[winner]=1 in the same cycle; req_data slice captured into cdc_data.
//    rr_ptr <= (winner+1)%N_REQ; grant_idx <= winner; go to HOLD with cdc_en<=1 and cnt<=EN_CYC-1.
//   HOLD: cdc_en=1; count down; at cnt==0 go to GAP with cdc_en<=0 and cnt<=GAP_CYC-1.
//   GAP: cdc_en=0; count down; at cnt==0 go to IDLE.
//  req_ready is 0 outside IDLE. At most one req_ready bit is ever high.
//  Timing, with accept in cycle t:
//   cdc_en=1 in cycles t+1 .. t+EN_CYC.
//   cdc_en=0 in cycles t+EN_CYC+1 .. t+EN_CYC+GAP_CYC.
//   Next accept possible at t+EN_CYC+GAP_CYC+1. Peak rate is 1 word per EN_CYC+GAP_CYC+1 cycles.
//  cdc_data changes only in the cycle after an accept, and stays constant through HOLD and GAP.
//  Requesters hold req_valid and req_data until they see req_ready. Ungranted req_data is ignored.
//  A requester deasserting valid before grant is legal: it is simply not selected.
//  No valid in IDLE: state, rr_ptr and outputs hold their values.
//  Reset mid-operation: all state clears asynchronously. cdc_en falls without completing HOLD.
//  The downstream synchronizer then sees a short pulse, which is accepted behaviour.
//  Counter width is $clog2(max(EN_CYC,GAP_CYC)+1); no wrap is possible.
//  Elaboration fails if N_REQ<2, EN_CYC<1 or GAP_CYC<1.
// CONFIGURATION
//  Macro MUX_ARB_TAG_EN:
//   Defined: cdc_data = {winner[IDX_W-1:0], payload}, OUT_W = DATA_W+IDX_W. The tag is captured and held with the payload.
//   Undefined: cdc_data = payload only, OUT_W = DATA_W. Ports and timing are otherwise identical.
// STRUCTURE
//  Package mux_arb_pkg holds:
//   state typedef arb_state_t {IDLE, HOLD, GAP}.
//   cnt_w(EN_CYC,GAP_CYC) helper and the idx_w(N_REQ) helper.
//  Sub-module rr_pick: combinational round-robin picker.
//   Inputs: valid vector, rr_ptr. Outputs: one-hot grant, winner index, any_valid.
//  The top module holds the FSM, counter, rr_ptr and output registers.
// TESTING  (N_REQ=4, DATA_W=8, EN_CYC=3, GAP_CYC=4)
//  1. rst=1 with req_valid=4'hF -> cdc_en=0, cdc_data=0, req_ready=0, busy=0 throughout reset.
//  2. After reset, req_valid=4'b0100 with data 8'hA5 at cycle 0 ->
//     req_ready=4'b0100 at cycle 0; cdc_en=1 in cycles 1-3; cdc_data=8'hA5 in cycles 1-7; busy=0 at cycle 8.
//  3. req_valid=4'hF held with new data after each grant -> grants 0,1,2,3,0, exactly 8 cycles apart.
//  4. rr_ptr=2 with req_valid=4'b1010 -> grant 3 first, then 1 on the next accept.
//  5. rst pulsed during HOLD cycle 2 -> cdc_en=0 immediately; after release, IDLE and req_valid=4'b1000 grants 3.
//  6. MUX_ARB_TAG_EN defined, requester 3 sends 8'h3C -> cdc_data=10'h33C in cycles 1-7.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and sizing helpers for the mux+n-flop CDC channel arbiter.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    // Wide enough to hold the larger of the two preload values without wrap.
    function automatic int cnt_w(input int en_cyc, input int gap_cyc);
        int m;
        m = (en_cyc > gap_cyc) ? en_cyc : gap_cyc;
        return $clog2(m + 1);
    endfunction

    function automatic int idx_w(input int n_req);
        return (n_req < 2) ? 1 : $clog2(n_req);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first valid index at or after rr_ptr, wrapping.
// Latency: combinational. Backpressure: none, pure selection logic.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] winner,
    output logic             any_valid
);

    logic [IDX_W:0] sum;

    // Walk offsets from farthest to nearest so the nearest valid index wins.
    always_comb begin
        grant     = '0;
        winner    = '0;
        sum       = '0;
        any_valid = |valid;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(N_REQ)) begin
                sum = sum - (IDX_W + 1)'(N_REQ);
            end
            if (valid[sum[IDX_W-1:0]]) begin
                winner = sum[IDX_W-1:0];
            end
        end
        if (any_valid) begin
            grant[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/mux_ndff_tx_arb.sv
// Round-robin arbiter feeding one mux+n-flop CDC channel; MUX_ARB_TAG_EN prepends the winner index.
// Latency: accept to cdc_en high is 1 cycle; en held EN_CYC cycles, then low GAP_CYC cycles.
// Backpressure: req_ready only in IDLE; requesters hold valid/data until granted.
module mux_ndff_tx_arb
    import mux_arb_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int DATA_W  = 8,
    parameter  int EN_CYC  = 3,
    parameter  int GAP_CYC = 4,
    localparam int IDX_W   = idx_w(N_REQ),
`ifdef MUX_ARB_TAG_EN
    localparam int OUT_W   = DATA_W + IDX_W
`else
    localparam int OUT_W   = DATA_W
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [OUT_W-1:0]          cdc_data,
    output logic                      cdc_en,
    output logic                      busy,
    output logic [IDX_W-1:0]          grant_idx
);

    localparam int CW = cnt_w(EN_CYC, GAP_CYC);

    if (N_REQ < 2 || EN_CYC < 1 || GAP_CYC < 1) begin : g_bad_cfg
        $fatal(1, "mux_ndff_tx_arb: need N_REQ>=2, EN_CYC>=1, GAP_CYC>=1");
    end

    arb_state_t         state;
    logic [CW-1:0]      cnt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   nxt_ptr;
    logic [N_REQ-1:0]   grant;
    logic [IDX_W-1:0]   winner;
    logic               any_valid;
    logic [DATA_W-1:0]  slices [N_REQ];
    logic [OUT_W-1:0]   win_word;

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign slices[i] = req_data[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid     (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .winner    (winner),
        .any_valid (any_valid)
    );

    always_comb begin
        nxt_ptr = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
`ifdef MUX_ARB_TAG_EN
        win_word = {winner, slices[winner]};
`else
        win_word = slices[winner];
`endif
    end

    // Gated by rst so no handshake completes while reset is asserted.
    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rr_ptr    <= '0;
            grant_idx <= '0;
            cdc_en    <= 1'b0;
            cdc_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        cdc_data  <= win_word;
                        grant_idx <= winner;
                        rr_ptr    <= nxt_ptr;
                        cdc_en    <= 1'b1;
                        cnt       <= CW'(EN_CYC - 1);
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        cdc_en <= 1'b0;
                        cnt    <= CW'(GAP_CYC - 1);
                        state  <= GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cdc_en <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

endmodule
